mult_8x8_err_acc: RTL and testbench
===================================

# mult_8x8_err_acc

Streaming error-metric accumulator that sits directly downstream of the approximate 8×8 multipliers. It consumes operand pairs A, B together with the approximate product R, and for each pair computes the exact product and the error distance ED = |A·B − R|. Over a run of N_SAMPLES accepted samples it accumulates sum(ED), max(ED) and the number of erroneous samples. The result characterises any multiplier variant in simulation or on FPGA without changing the multiplier itself.

## Interface
Parameters:
- N_SAMPLES, 256: samples per run; must be ≥ 1.
- CNT_W, $clog2(N_SAMPLES+1): width of the sample and error counters.
- SUM_W, 16+CNT_W: width of the ED sum; it cannot overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears the accumulators and begins a run. Honoured in IDLE and DONE only.
- in_valid  in  1  sample present on a/b/r.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- a  in  8  operand A (unsigned).
- b  in  8  operand B (unsigned).
- r  in  16  approximate product from the multiplier under test.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; held until start or rst.
- sum_ed  out  SUM_W  Σ ED over the run.
- max_ed  out  16  maximum ED over the run.
- err_cnt  out  CNT_W  count of samples with ED ≠ 0.
- smp_cnt  out  CNT_W  count of accepted samples.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN on the cycle that accepts sample N_SAMPLES.
  - DRAIN → DONE when the pipeline is empty (3 cycles).
  - DONE → RUN on start.
- On a start that is honoured: sum_ed, max_ed, err_cnt and smp_cnt clear to 0 and pipeline valids clear, all on the same edge.
- start is ignored in RUN and DRAIN.
- in_ready = (state == RUN). It is combinational from state only and never depends on in_valid.
- Pipeline:
  - S1 registers a·b (16-bit exact product) and r.
  - S2 registers ED = (exact ≥ r) ? exact − r : r − exact, unsigned 16-bit.
  - S3 accumulation, on valid S2 only:
    - sum_ed += ED
    - max_ed = max(max_ed, ED)
    - err_cnt += (ED ≠ 0)
- smp_cnt increments on acceptance, not on accumulation.
- Bubbles (in_valid low) propagate as invalid stages and leave the accumulators unchanged.
- Reset, asserted at any time (including mid-run): state = IDLE and all outputs 0 (in_ready, busy, done, sum_ed, max_ed, err_cnt, smp_cnt). All pipeline valids clear.
- Output values are stable and final only while done = 1. During RUN they are partial.

## Timing
- Sample accepted at edge t: S1 valid after t+1, S2 after t+2, accumulated into sum_ed/max_ed/err_cnt after t+3.
- Last accept at edge t: state = DRAIN after t; done = 1 and all outputs final after t+3.
- Minimum run length for back-to-back input: N_SAMPLES + 4 cycles from the start pulse to done (1 cycle start, N accepts, 3 drain).
- start arriving on the same cycle done rises (i.e. in DRAIN) is ignored.

## Structure
- Shared package mult_err_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - localparam PROD_W = 16;
  - a function abs_diff16(a, b).
- One sub-module, mult_ed_stage: S1 and S2 (exact multiply, register, absolute difference, valid pipe). The top level holds the FSM, the counters and S3.
- The exact product uses the behavioural `*` operator. This block is the golden reference and must itself be exact.

## Test plan
- Exact stream: N_SAMPLES = 4; samples (3,5,r=15), (255,255,r=65025), (0,7,r=0), (16,16,r=256). Expect done, sum_ed = 0, max_ed = 0, err_cnt = 0, smp_cnt = 4.
- Mixed errors: N_SAMPLES = 4; (255,255,r=65024) ED=1, (10,10,r=110) ED=10, (0,0,r=65535) ED=65535, (2,2,r=4) ED=0. Expect sum_ed = 65546, max_ed = 65535, err_cnt = 3.
- Backpressure and bubbles: same samples as the mixed-errors case with in_valid toggled 1,0,0,1,0,1,1. Expect identical results. Expect done exactly 3 cycles after the 4th accept, and in_ready = 0 after the 4th accept.
- Start ignored/restart: pulse start during RUN, expect no effect on counts. After done, pulse start, expect all outputs 0 on the next cycle and a second run's results independent of the first.
- Reset mid-run: assert rst after 2 of 4 accepts. Expect all outputs 0 and state IDLE immediately (asynchronously). A subsequent start and full run yields correct totals with no residue from in-flight samples.
- Full default run: N_SAMPLES = 256; sweep a = i, b = 255 − i, r = exact ^ 16'h0001. Expect err_cnt = 256, max_ed = 1, sum_ed = 256.

Source files
------------

// File: rtl/mult_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error accumulator.
// Holds the run-state encoding, the product width and the absolute-difference helper.
package mult_err_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [PROD_W-1:0] abs_diff16(input logic [PROD_W-1:0] x,
                                                   input logic [PROD_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/mult_ed_stage.sv
// Stages S1/S2: exact 8x8 product registered next to the approximate result,
// then the registered error distance |exact - r|, each with its own valid bit.
module mult_ed_stage
  import mult_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [7:0]        i_a,
  input  logic [7:0]        i_b,
  input  logic [PROD_W-1:0] i_r,
  output logic              o_valid,
  output logic [PROD_W-1:0] o_ed
);

  logic              r_s1_vld;
  logic [PROD_W-1:0] r_s1_prod;
  logic [PROD_W-1:0] r_s1_r;
  logic              r_s2_vld;
  logic [PROD_W-1:0] r_s2_ed;
  logic [PROD_W-1:0] w_prod;

  // This block is the golden reference, so the product stays the plain operator.
  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s1_prod <= '0;
      r_s1_r    <= '0;
      r_s2_ed   <= '0;
    end else begin
      if (i_flush) begin
        r_s1_vld <= 1'b0;
        r_s2_vld <= 1'b0;
      end else begin
        r_s1_vld <= i_valid;
        r_s2_vld <= r_s1_vld;
      end
      if (i_valid) begin
        r_s1_prod <= w_prod;
        r_s1_r    <= i_r;
      end
      if (r_s1_vld) begin
        r_s2_ed <= abs_diff16(r_s1_prod, r_s1_r);
      end
    end
  end

  assign o_valid = r_s2_vld;
  assign o_ed    = r_s2_ed;

endmodule

// File: rtl/mult_8x8_err_acc.sv
// Run-based error-metric accumulator: sums, maximises and counts |A*B - R|
// over N_SAMPLES accepted samples, then holds the totals in DONE.
module mult_8x8_err_acc
  import mult_err_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1),
  parameter int SUM_W     = 16 + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends on state alone, and a/b/r are ignored when no transfer occurs.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic [15:0]       r,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [15:0]       max_ed,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  smp_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SAMPLES - 1);
  localparam logic [1:0]       DRAIN_END = 2'd2;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_drain_cnt;
  logic [SUM_W-1:0]  r_sum_ed;
  logic [15:0]       r_max_ed;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_smp_cnt;
  logic              w_accept;
  logic              w_honour;
  logic              w_s2_vld;
  logic [PROD_W-1:0] w_s2_ed;

  assign in_ready = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_DONE);
  assign w_accept = in_valid && in_ready;
  assign w_honour = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  mult_ed_stage u_ed_stage (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_honour),
    .i_valid (w_accept),
    .i_a     (a),
    .i_b     (b),
    .i_r     (r),
    .o_valid (w_s2_vld),
    .o_ed    (w_s2_ed)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && (r_smp_cnt == LAST_IDX)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_drain_cnt == DRAIN_END) w_state_nxt = ST_DONE;
      ST_DONE:  if (start) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
    end
  end

  // The last accepted sample reaches S3 on the same edge that DRAIN hands over to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
      r_err_cnt <= '0;
      r_smp_cnt <= '0;
    end else if (w_honour) begin
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
      r_err_cnt <= '0;
      r_smp_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_smp_cnt <= r_smp_cnt + CNT_W'(1);
      end
      if (w_s2_vld) begin
        r_sum_ed <= r_sum_ed + SUM_W'(w_s2_ed);
        if (w_s2_ed > r_max_ed) begin
          r_max_ed <= w_s2_ed;
        end
        if (w_s2_ed != '0) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sum_ed  = r_sum_ed;
  assign max_ed  = r_max_ed;
  assign err_cnt = r_err_cnt;
  assign smp_cnt = r_smp_cnt;

endmodule

// File: tb/tb_mult_8x8_err_acc.sv
// Bench for mult_8x8_err_acc: a 4-sample instance for directed/random runs and a
// 256-sample instance for the full sweep, both checked against an arithmetic model.
module tb_mult_8x8_err_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4;
  logic        start256;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] r;

  logic        rdy4, busy4, done4;
  logic [18:0] sum4;
  logic [15:0] max4;
  logic [2:0]  err4, smp4;

  logic        rdy256, busy256, done256;
  logic [24:0] sum256;
  logic [15:0] max256;
  logic [8:0]  err256, smp256;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  logic [15:0] q_r[$];
  logic [15:0] pat;
  int          pat_len;

  always #5 clk = ~clk;

  mult_8x8_err_acc #(.N_SAMPLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
    .a(a), .b(b), .r(r), .busy(busy4), .done(done4), .sum_ed(sum4),
    .max_ed(max4), .err_cnt(err4), .smp_cnt(smp4)
  );

  mult_8x8_err_acc #(.N_SAMPLES(256)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .in_valid(in_valid), .in_ready(rdy256),
    .a(a), .b(b), .r(r), .busy(busy256), .done(done256), .sum_ed(sum256),
    .max_ed(max256), .err_cnt(err256), .smp_cnt(smp256)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_sum(input bit sel);
    return sel ? 32'(sum256) : 32'(sum4);
  endfunction
  function automatic logic [31:0] o_max(input bit sel);
    return sel ? 32'(max256) : 32'(max4);
  endfunction
  function automatic logic [31:0] o_err(input bit sel);
    return sel ? 32'(err256) : 32'(err4);
  endfunction
  function automatic logic [31:0] o_smp(input bit sel);
    return sel ? 32'(smp256) : 32'(smp4);
  endfunction

  task automatic clear_q();
    q_a.delete(); q_b.delete(); q_r.delete();
  endtask

  task automatic push(input int va, input int vb, input int vr);
    q_a.push_back(8'(va)); q_b.push_back(8'(vb)); q_r.push_back(16'(vr));
  endtask

  // Reference: error distance straight from the definition, over whole queue.
  task automatic model(output longint s, output longint mx, output longint e);
    s = 0; mx = 0; e = 0;
    foreach (q_a[i]) begin
      longint d;
      d = longint'(q_a[i]) * longint'(q_b[i]) - longint'(q_r[i]);
      if (d < 0) d = -d;
      s += d;
      if (d > mx) mx = d;
      if (d != 0) e++;
    end
  endtask

  task automatic check_zero(input bit sel, input string tag);
    chk({tag, "_sum"}, o_sum(sel), 0);
    chk({tag, "_max"}, o_max(sel), 0);
    chk({tag, "_err"}, o_err(sel), 0);
    chk({tag, "_smp"}, o_smp(sel), 0);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start256 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start256 = 1'b0;
    chk("start_busy", 32'(sel ? busy256 : busy4), 1);
  endtask

  // mode 0: always valid, 1: valid from pat, 2: random valid
  task automatic run_samples(input bit sel, input int mode, input int abort_after,
                             input bit mid_start);
    int  idx = 0;
    int  cyc = 0;
    bit  sent = 1'b0;
    bit  v;
    bit  acc;
    while (idx < q_a.size() && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc < pat_len) ? pat[cyc] : 1'b1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      a = v ? q_a[idx] : 8'($urandom);
      b = v ? q_b[idx] : 8'($urandom);
      r = v ? q_r[idx] : 16'($urandom);
      if (mid_start && idx == 2 && !sent) begin
        sent = 1'b1;
        if (sel) start256 = 1'b1; else start4 = 1'b1;
      end
      acc = v && (sel ? rdy256 : rdy4);
      @(posedge clk); #1;
      start4 = 1'b0; start256 = 1'b0;
      if (acc) idx++;
      cyc++;
      if (abort_after > 0 && idx == abort_after) break;
    end
    in_valid = 1'b0;
    if (cyc >= 2000) chk("accept_timeout", 32'(idx), 32'(q_a.size()));
  endtask

  // Called just after the last accepting edge; done must rise on the third edge.
  task automatic finish_run(input bit sel, input string tag);
    longint s, mx, e;
    chk({tag, "_rdy_after_last"}, 32'(sel ? rdy256 : rdy4), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk({tag, "_done_k"}, 32'(sel ? done256 : done4), (k == 3) ? 1 : 0);
    end
    model(s, mx, e);
    chk({tag, "_sum"}, o_sum(sel), 32'(s));
    chk({tag, "_max"}, o_max(sel), 32'(mx));
    chk({tag, "_err"}, o_err(sel), 32'(e));
    chk({tag, "_smp"}, o_smp(sel), 32'(q_a.size()));
    chk({tag, "_busy"}, 32'(sel ? busy256 : busy4), 0);
  endtask

  task automatic load_mixed();
    clear_q();
    push(255, 255, 65024); push(10, 10, 110); push(0, 0, 65535); push(2, 2, 4);
  endtask

  task automatic load_random(input int n);
    clear_q();
    for (int i = 0; i < n; i++) begin
      int ra, rb, ex;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      ex = ra * rb;
      case ($urandom_range(0, 3))
        0:       push(ra, rb, ex);
        1:       push(ra, rb, ex ^ int'($urandom_range(0, 255)));
        2:       push(ra, rb, int'($urandom_range(0, 65535)));
        default: push(ra, rb, ex ^ (1 << $urandom_range(0, 15)));
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start256 = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; r = '0;
    #1;
    check_zero(0, "rst4");
    check_zero(1, "rst256");
    chk("rst_rdy", 32'(rdy4), 0);
    chk("rst_done", 32'(done4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // exact stream
    clear_q();
    push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0); push(16, 16, 256);
    pulse_start(0);
    check_zero(0, "restart_clear");
    run_samples(0, 0, 0, 1'b0);
    finish_run(0, "exact");
    chk("exact_sum_const", o_sum(0), 0);

    // mixed errors
    load_mixed();
    pulse_start(0);
    check_zero(0, "done_restart");
    run_samples(0, 0, 0, 1'b0);
    finish_run(0, "mixed");
    chk("mixed_sum_const", o_sum(0), 65546);

    // bubbles: 1,0,0,1,0,1,1
    pat = 16'b0000_0000_0110_1001; pat_len = 7;
    pulse_start(0);
    run_samples(0, 1, 0, 1'b0);
    finish_run(0, "bubble");

    // start during RUN ignored
    load_random(4);
    pulse_start(0);
    run_samples(0, 0, 0, 1'b1);
    finish_run(0, "mid_start");

    // reset mid-run after two accepts
    load_mixed();
    pulse_start(0);
    run_samples(0, 0, 2, 1'b0);
    rst = 1'b1;
    #1;
    check_zero(0, "midrst");
    chk("midrst_busy", 32'(busy4), 0);
    chk("midrst_rdy", 32'(rdy4), 0);
    chk("midrst_done", 32'(done4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pulse_start(0);
    run_samples(0, 0, 0, 1'b0);
    finish_run(0, "post_rst");

    // randomized runs with random bubbles
    for (int t = 0; t < 6; t++) begin
      load_random(4);
      pulse_start(0);
      run_samples(0, 2, 0, 1'b0);
      finish_run(0, "rand");
    end

    // full default sweep
    clear_q();
    for (int i = 0; i < 256; i++) push(i, 255 - i, (i * (255 - i)) ^ 1);
    pulse_start(1);
    run_samples(1, 0, 0, 1'b0);
    finish_run(1, "sweep");
    chk("sweep_sum_const", o_sum(1), 256);
    chk("sweep_max_const", o_max(1), 1);

    // random full run with bubbles on the large instance
    load_random(256);
    pulse_start(1);
    run_samples(1, 2, 0, 1'b0);
    finish_run(1, "rand256");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
